// File: rtl/mem_pkg.sv
// Shared types for the BRAM port-B sharing logic.
// Holds the read-return owner tag, the arbiter state encoding and byte-enable constants.
// Imported by ram_port_arbiter and rd_return_pipe.
package mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_LDR  = 2'd2,
        S_BOOT = 2'd3
    } arb_state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return pipeline: one {valid, owner} register tracking the read issued last cycle,
// and steering of the BRAM q output to the requester that owns it.
// Ports: clk/reset; rd_acc + rd_owner (read accepted this cycle); mem_q in; per-owner rvalid/rdata out.
module rd_return_pipe
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_acc,
    input  logic [1:0]  rd_owner,
    input  logic [31:0] mem_q,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata
);

    logic       pipe_vld;
    logic [1:0] pipe_own;

    // BRAM q lands one cycle after the address, so a single stage aligns the tag with the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= 1'b0;
            pipe_own <= OWN_NONE;
        end else begin
            pipe_vld <= rd_acc;
            pipe_own <= rd_acc ? rd_owner : OWN_NONE;
        end
    end

    assign cpu_rvalid = pipe_vld && (pipe_own == OWN_CPU);
    assign ldr_rvalid = pipe_vld && (pipe_own == OWN_LDR);
    // Non-owners see zero so stale q never leaks onto an idle return bus.
    assign cpu_rdata  = cpu_rvalid ? mem_q : 32'd0;
    assign ldr_rdata  = ldr_rvalid ? mem_q : 32'd0;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares BRAM port B between the CPU load/store path and the boot/debug loader.
// Ports: clk_ram/reset; cpu_* and ldr_* request/grant/read-return groups; mem_* to the BRAM; busy status.
// Arbitration is fixed-priority to the CPU with a starvation limit; boot_hold gives the loader exclusive use.
module ram_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_ram,
    input  logic              reset,
    input  logic              boot_hold,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adrs,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_adrs,
    input  logic [3:0]        ldr_be,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_q,
    output logic              busy
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    arb_state_t state;
    arb_state_t state_nxt;
    logic [7:0] burst_cnt;
    logic       ldr_turn;
    logic       cpu_win;
    logic       ldr_win;
    logic       rd_acc;
    logic [1:0] rd_owner;

    // Loader gets one slot once the CPU has used its whole burst allowance.
    assign ldr_turn = (burst_cnt == BURST_LIM);

    // Wins are gated by reset so no grant (and no BRAM write) escapes while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        ldr_win = 1'b0;
        if (reset) begin
            if (boot_hold) begin
                ldr_win = ldr_req;
            end else if (cpu_req && ldr_req) begin
                ldr_win = ldr_turn;
                cpu_win = !ldr_turn;
            end else begin
                cpu_win = cpu_req;
                ldr_win = ldr_req;
            end
        end
    end

    assign cpu_gnt = cpu_win;
    assign ldr_gnt = ldr_win;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = BE_ALL;
        mem_adrs  = '0;
        mem_wdata = 32'd0;
        rd_acc    = 1'b0;
        rd_owner  = OWN_NONE;
        if (cpu_win) begin
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_adrs  = cpu_adrs;
            mem_wdata = cpu_wdata;
            rd_acc    = !cpu_we;
            rd_owner  = OWN_CPU;
        end else if (ldr_win) begin
            mem_we    = ldr_we;
            mem_be    = ldr_be;
            mem_adrs  = ldr_adrs;
            mem_wdata = ldr_wdata;
            rd_acc    = !ldr_we;
            rd_owner  = OWN_LDR;
        end
    end

    always_comb begin
        if (boot_hold)    state_nxt = S_BOOT;
        else if (cpu_win) state_nxt = S_CPU;
        else if (ldr_win) state_nxt = S_LDR;
        else              state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            burst_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            // The count only measures starvation of a waiting loader; boot_hold
            // also clears it so arbitration restarts fresh when the hold drops.
            if (!ldr_req || ldr_win || boot_hold) begin
                burst_cnt <= 8'd0;
            end else if (cpu_win && !ldr_turn) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    assign busy = boot_hold || (state == S_LDR);

    rd_return_pipe u_rd_return_pipe (
        .clk        (clk_ram),
        .reset      (reset),
        .rd_acc     (rd_acc),
        .rd_owner   (rd_owner),
        .mem_q      (mem_q),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata)
    );

    // An unknown request would otherwise be silently arbitrated as either value.
    a_req_known: assert property (@(posedge clk_ram) disable iff (!reset)
        !$isunknown({cpu_req, ldr_req, boot_hold}));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: BRAM behavioural model, directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int MAXB   = 8;

    logic              clk_ram;
    logic              reset;
    logic              boot_hold;
    logic              cpu_req, cpu_we, ldr_req, ldr_we;
    logic [ADDR_W-1:0] cpu_adrs, ldr_adrs;
    logic [3:0]        cpu_be, ldr_be;
    logic [31:0]       cpu_wdata, ldr_wdata;
    logic              cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0]       cpu_rdata, ldr_rdata;
    logic [ADDR_W-1:0] mem_adrs;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_q;
    logic              mem_we, busy;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAXB)) dut (
        .clk_ram(clk_ram), .reset(reset), .boot_hold(boot_hold),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adrs(ldr_adrs), .ldr_be(ldr_be),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_adrs(mem_adrs), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_q(mem_q), .busy(busy)
    );

    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    // ---------------- BRAM model (256 words, address aliased on low 8 bits) ----------------
    logic        tb_init;
    logic [31:0] bram [256];
    always @(posedge clk_ram) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
            mem_q <= 32'd0;
        end else begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bram[mem_adrs[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_q <= bram[mem_adrs[7:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model, evaluated once per cycle ----------------
    logic [31:0] mmem [256];
    int          m_cnt;      // CPU wins since the loader started waiting
    logic        m_pv;       // a read was accepted last cycle
    int          m_po;       // 1 = CPU owns it, 2 = loader
    logic [31:0] m_pd;       // data that read must return
    logic        m_ldr_st;   // last cycle's winner was the loader outside boot_hold
    logic        model_on;

    always @(negedge clk_ram) begin
        logic        ecw, elw, ewe;
        logic [3:0]  ebe;
        logic [15:0] ead;
        logic [31:0] ewd;
        if (model_on) begin
            ecw = 1'b0; elw = 1'b0;
            if (!reset) begin
                ecw = 1'b0; elw = 1'b0;
            end else if (boot_hold) begin
                elw = ldr_req;
            end else if (cpu_req && ldr_req) begin
                elw = (m_cnt == MAXB);
                ecw = !elw;
            end else begin
                ecw = cpu_req; elw = ldr_req;
            end
            ewe = 1'b0; ebe = 4'hF; ead = 16'd0; ewd = 32'd0;
            if (ecw) begin ewe = cpu_we; ebe = cpu_be; ead = cpu_adrs; ewd = cpu_wdata; end
            if (elw) begin ewe = ldr_we; ebe = ldr_be; ead = ldr_adrs; ewd = ldr_wdata; end
            if (!reset) m_pv = 1'b0;

            chk("cpu_gnt",   32'(cpu_gnt),   32'(ecw));
            chk("ldr_gnt",   32'(ldr_gnt),   32'(elw));
            chk("mem_we",    32'(mem_we),    32'(ewe));
            chk("mem_be",    32'(mem_be),    32'(ebe));
            chk("mem_adrs",  32'(mem_adrs),  32'(ead));
            chk("mem_wdata", mem_wdata,      ewd);
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pv && m_po == 1));
            chk("cpu_rdata",  cpu_rdata, (m_pv && m_po == 1) ? m_pd : 32'd0);
            chk("ldr_rvalid", 32'(ldr_rvalid), 32'(m_pv && m_po == 2));
            chk("ldr_rdata",  ldr_rdata, (m_pv && m_po == 2) ? m_pd : 32'd0);
            chk("busy",       32'(busy), 32'(boot_hold || (reset && m_ldr_st)));

            if (!reset) begin
                m_cnt = 0; m_pv = 1'b0; m_po = 0; m_ldr_st = 1'b0;
            end else begin
                m_pv = (ecw || elw) && !ewe;
                m_po = ecw ? 1 : (elw ? 2 : 0);
                m_pd = mmem[ead[7:0]];
                if ((ecw || elw) && ewe)
                    for (int b = 0; b < 4; b++)
                        if (ebe[b]) mmem[ead[7:0]][8*b +: 8] = ewd[8*b +: 8];
                if (!ldr_req || elw || boot_hold) m_cnt = 0;
                else if (ecw && m_cnt < MAXB) m_cnt = m_cnt + 1;
                m_ldr_st = !boot_hold && elw;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic idle_reqs();
        cpu_req = 1'b0; ldr_req = 1'b0;
    endtask

    task automatic set_cpu(input logic we, input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_adrs = a; cpu_be = be; cpu_wdata = d;
    endtask

    task automatic set_ldr(input logic we, input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        ldr_req = 1'b1; ldr_we = we; ldr_adrs = a; ldr_be = be; ldr_wdata = d;
    endtask

    initial begin
        int first_l, second_l, both_hi, l_cnt;
        logic cg_prev, lg_prev;

        for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
        m_cnt = 0; m_pv = 1'b0; m_po = 0; m_pd = 32'd0; m_ldr_st = 1'b0;
        tb_init = 1'b1; model_on = 1'b1;
        reset = 1'b0; boot_hold = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_adrs = 0; cpu_be = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_adrs = 0; ldr_be = 0; ldr_wdata = 0;

        // Reset state
        @(negedge clk_ram);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_rvalid",  32'(cpu_rvalid | ldr_rvalid), 32'd0);
        chk("rst_mem_we",  32'(mem_we), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        tick();
        tb_init = 1'b0;
        reset = 1'b1;
        tick();

        // CPU read of 0x0010
        set_cpu(1'b0, 16'h0010, 4'hF, 32'd0);
        @(negedge clk_ram);
        chk("rd1_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd1_adrs", 32'(mem_adrs), 32'h10);
        tick();
        idle_reqs();
        @(negedge clk_ram);
        chk("rd1_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd1_ldr_quiet", 32'(ldr_rvalid) | ldr_rdata | 32'(ldr_gnt), 32'd0);
        tick();

        // Both requesting continuously: 8 CPU, 1 loader, repeat
        set_cpu(1'b0, 16'h0030, 4'hF, 32'd0);
        set_ldr(1'b0, 16'h0031, 4'hF, 32'd0);
        first_l = -1; second_l = -1; both_hi = 0; l_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_ram);
            if (cpu_gnt && ldr_gnt) both_hi++;
            if (ldr_gnt) begin
                if (l_cnt == 0) first_l = c; else if (l_cnt == 1) second_l = c;
                l_cnt++;
            end
            tick();
        end
        chk("burst_first_ldr", 32'(first_l), 32'd8);
        chk("burst_second_ldr", 32'(second_l), 32'd17);
        chk("burst_two_gnts", 32'(both_hi), 32'd0);
        idle_reqs();
        tick();

        // boot_hold: loader write while CPU waits
        boot_hold = 1'b1;
        set_ldr(1'b1, 16'h0004, 4'b0011, 32'h12345678);
        set_cpu(1'b0, 16'h0005, 4'hF, 32'd0);
        @(negedge clk_ram);
        chk("boot_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("boot_ldr_gnt", 32'(ldr_gnt), 32'd1);
        chk("boot_mem_we", 32'(mem_we), 32'd1);
        chk("boot_mem_be", 32'(mem_be), 32'h3);
        chk("boot_busy", 32'(busy), 32'd1);
        tick();
        ldr_req = 1'b0;
        @(negedge clk_ram);
        chk("boot_cpu_wait", 32'(cpu_gnt), 32'd0);
        tick();
        boot_hold = 1'b0;
        @(negedge clk_ram);
        chk("boot_release_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle_reqs();
        @(negedge clk_ram);
        chk("boot_cpu_rdata", cpu_rdata, 32'hC0DE0005);
        tick();

        // Loader reads 0,1,2 back-to-back, then read back the boot-written word
        for (int a = 0; a < 4; a++) begin
            if (a < 3) set_ldr(1'b0, 16'(a), 4'hF, 32'd0);
            else       set_ldr(1'b0, 16'h0004, 4'hF, 32'd0);
            @(negedge clk_ram);
            if (a > 0) begin
                chk("ldr_b2b_rvalid", 32'(ldr_rvalid), 32'd1);
                chk("ldr_b2b_rdata", ldr_rdata, 32'hC0DE0000 | 32'(a - 1));
            end
            tick();
        end
        idle_reqs();
        @(negedge clk_ram);
        chk("ldr_boot_word", ldr_rdata, 32'hC0DE5678);
        tick();

        // Reset in the cycle after a CPU read is accepted
        set_cpu(1'b0, 16'h0010, 4'hF, 32'd0);
        @(negedge clk_ram);
        chk("rstrd_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        idle_reqs();
        reset = 1'b0;
        @(negedge clk_ram);
        chk("rstrd_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rstrd_mem_we", 32'(mem_we), 32'd0);
        chk("rstrd_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk_ram);
        chk("rstrd_after", 32'(cpu_rvalid), 32'd0);
        tick();

        // CPU write then read of the same address
        set_cpu(1'b1, 16'h0020, 4'hF, 32'hCAFEF00D);
        @(negedge clk_ram);
        chk("wr_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        set_cpu(1'b0, 16'h0020, 4'hF, 32'd0);
        @(negedge clk_ram);
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        idle_reqs();
        @(negedge clk_ram);
        chk("wr_readback", cpu_rdata, 32'hCAFEF00D);
        tick();

        // Randomized traffic; requesters hold fields until granted
        cg_prev = 1'b1; lg_prev = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!cpu_req || cg_prev) begin
                cpu_req = ($urandom_range(0, 9) < 8);
                cpu_we = $urandom_range(0, 1); cpu_adrs = 16'($urandom);
                cpu_be = 4'($urandom); cpu_wdata = $urandom;
            end
            if (!ldr_req || lg_prev) begin
                ldr_req = ($urandom_range(0, 9) < 7);
                ldr_we = $urandom_range(0, 1); ldr_adrs = 16'($urandom);
                ldr_be = 4'($urandom); ldr_wdata = $urandom;
            end
            if ($urandom_range(0, 49) == 0) boot_hold = !boot_hold;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) reset = 1'b0;
            @(negedge clk_ram);
            cg_prev = cpu_gnt; lg_prev = ldr_gnt;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
